// File: rtl/dll_lock_ctrl.sv
// Digital lock controller for the DLL: filters early/late phase-detector samples and steps
// the delay-line code through coarse acquisition, fine tracking and lock detection.
module dll_lock_ctrl #(
   parameter int CODE_W      = 6,
   parameter int CODE_INIT   = 32,
   parameter int FILT_W      = 4,
   parameter int FILT_THR    = 4,
   parameter int COARSE_STEP = 4,
   parameter int LOCK_REV    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              pd_early,
   input  logic              pd_late,
   output logic [CODE_W-1:0] delay_code,
   output logic              upd_strobe,
   output logic              locked,
   output logic              fault,
   output logic [2:0]        state
);

   localparam int REV_W = $clog2(LOCK_REV + 1);

   localparam logic [CODE_W-1:0]        CODE_MAX  = {CODE_W{1'b1}};
   localparam logic [CODE_W-1:0]        CODE_ZERO = {CODE_W{1'b0}};
   localparam logic [CODE_W-1:0]        CODE_RST  = CODE_W'(CODE_INIT);
   localparam logic [CODE_W-1:0]        CODE_ONE  = CODE_W'(1);
   localparam logic [CODE_W-1:0]        STEP_C    = CODE_W'(COARSE_STEP);
   localparam logic [REV_W-1:0]         REV_ZERO  = {REV_W{1'b0}};
   localparam logic [REV_W-1:0]         REV_ONE   = REV_W'(1);
   localparam logic [REV_W-1:0]         REV_LOCK  = REV_W'(LOCK_REV);
   localparam logic signed [FILT_W-1:0] ACC_ZERO  = {FILT_W{1'b0}};
   localparam logic signed [FILT_W:0]   D_ZERO    = {(FILT_W+1){1'b0}};
   localparam logic signed [FILT_W:0]   D_UP      = (FILT_W+1)'(1);
   localparam logic signed [FILT_W:0]   D_DN      = (FILT_W+1)'(-1);
   localparam logic signed [FILT_W:0]   THR_P     = (FILT_W+1)'(FILT_THR);
   localparam logic signed [FILT_W:0]   THR_N     = (FILT_W+1)'(-FILT_THR);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACQUIRE = 3'd1,
      ST_TRACK   = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_FAULT   = 3'd4
   } state_e;

   state_e                     state_q, state_d;
   logic [CODE_W-1:0]          code_q, code_d;
   logic signed [FILT_W-1:0]   acc_q, acc_d;
   logic [REV_W-1:0]           rev_cnt_q, rev_cnt_d;
   logic                       last_dir_q, last_dir_d;
   logic                       dir_valid_q, dir_valid_d;
   logic                       same_seen_q, same_seen_d;
   logic                       strobe_q, strobe_d;
   logic                       locked_q, locked_d;
   logic                       fault_q, fault_d;

   logic signed [FILT_W:0]     d_s;
   logic signed [FILT_W:0]     acc_ext_s;
   logic signed [FILT_W:0]     acc_n_s;
   logic                       ev_up_s;
   logic                       ev_dn_s;
   logic                       event_s;
   logic                       reversal_s;
   logic                       sat_s;
   logic [CODE_W-1:0]          fine_code_s;
   logic [CODE_W-1:0]          coarse_code_s;
   logic [REV_W-1:0]           rev_inc_s;

   // Loop filter, event decode and candidate codes for the current cycle
   always_comb begin
      d_s = D_ZERO;
      if (pd_early && !pd_late) begin
         d_s = D_UP;
      end else if (pd_late && !pd_early) begin
         d_s = D_DN;
      end else begin
         d_s = D_ZERO;
      end

      acc_ext_s  = {acc_q[FILT_W-1], acc_q};
      acc_n_s    = acc_ext_s + d_s;
      ev_up_s    = (acc_n_s >= THR_P);
      ev_dn_s    = (acc_n_s <= THR_N);
      event_s    = ev_up_s || ev_dn_s;
      // last_dir stores 1 for UP; it is meaningless until the first event of a run
      reversal_s = dir_valid_q && (ev_up_s != last_dir_q);
      sat_s      = (ev_up_s && (code_q == CODE_MAX)) || (ev_dn_s && (code_q == CODE_ZERO));
      rev_inc_s  = rev_cnt_q + REV_ONE;

      if (ev_up_s) begin
         fine_code_s = code_q + CODE_ONE;
      end else begin
         fine_code_s = code_q - CODE_ONE;
      end

      // Coarse steps clamp at the rails instead of wrapping
      if (ev_up_s) begin
         if (code_q > (CODE_MAX - STEP_C)) begin
            coarse_code_s = CODE_MAX;
         end else begin
            coarse_code_s = code_q + STEP_C;
         end
      end else begin
         if (code_q < STEP_C) begin
            coarse_code_s = CODE_ZERO;
         end else begin
            coarse_code_s = code_q - STEP_C;
         end
      end
   end

   // Next-state and next-output logic of the lock FSM
   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      acc_d       = acc_q;
      rev_cnt_d   = rev_cnt_q;
      last_dir_d  = last_dir_q;
      dir_valid_d = dir_valid_q;
      same_seen_d = same_seen_q;
      strobe_d    = 1'b0;

      if (!ena) begin
         state_d     = ST_IDLE;
         code_d      = CODE_RST;
         acc_d       = ACC_ZERO;
         rev_cnt_d   = REV_ZERO;
         dir_valid_d = 1'b0;
         same_seen_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_ACQUIRE;
               acc_d       = ACC_ZERO;
               dir_valid_d = 1'b0;
               same_seen_d = 1'b0;
            end

            ST_ACQUIRE: begin
               if (!event_s) begin
                  acc_d = acc_n_s[FILT_W-1:0];
               end else if (sat_s) begin
                  acc_d   = ACC_ZERO;
                  state_d = ST_FAULT;
               end else begin
                  acc_d       = ACC_ZERO;
                  strobe_d    = 1'b1;
                  last_dir_d  = ev_up_s;
                  dir_valid_d = 1'b1;
                  if (reversal_s) begin
                     code_d    = fine_code_s;
                     state_d   = ST_TRACK;
                     rev_cnt_d = REV_ONE;
                  end else begin
                     code_d = coarse_code_s;
                  end
               end
            end

            ST_TRACK: begin
               if (!event_s) begin
                  acc_d = acc_n_s[FILT_W-1:0];
               end else if (sat_s) begin
                  acc_d   = ACC_ZERO;
                  state_d = ST_FAULT;
               end else begin
                  acc_d       = ACC_ZERO;
                  strobe_d    = 1'b1;
                  code_d      = fine_code_s;
                  last_dir_d  = ev_up_s;
                  dir_valid_d = 1'b1;
                  if (!reversal_s) begin
                     rev_cnt_d = REV_ONE;
                  end else if (rev_inc_s >= REV_LOCK) begin
                     rev_cnt_d   = rev_inc_s;
                     state_d     = ST_LOCKED;
                     same_seen_d = 1'b0;
                  end else begin
                     rev_cnt_d = rev_inc_s;
                  end
               end
            end

            ST_LOCKED: begin
               if (!event_s) begin
                  acc_d = acc_n_s[FILT_W-1:0];
               end else if (sat_s) begin
                  acc_d   = ACC_ZERO;
                  state_d = ST_FAULT;
               end else begin
                  acc_d       = ACC_ZERO;
                  strobe_d    = 1'b1;
                  code_d      = fine_code_s;
                  last_dir_d  = ev_up_s;
                  dir_valid_d = 1'b1;
                  // A second same-direction event in a row means real drift, not dither
                  if (reversal_s) begin
                     same_seen_d = 1'b0;
                  end else if (same_seen_q) begin
                     same_seen_d = 1'b0;
                     state_d     = ST_TRACK;
                     rev_cnt_d   = REV_ONE;
                  end else begin
                     same_seen_d = 1'b1;
                  end
               end
            end

            ST_FAULT: begin
               state_d = ST_FAULT;
            end

            default: begin
               state_d     = ST_IDLE;
               code_d      = CODE_RST;
               acc_d       = ACC_ZERO;
               rev_cnt_d   = REV_ZERO;
               dir_valid_d = 1'b0;
               same_seen_d = 1'b0;
            end
         endcase
      end

      locked_d = (state_d == ST_LOCKED);
      fault_d  = (state_d == ST_FAULT);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         code_q      <= CODE_RST;
         acc_q       <= ACC_ZERO;
         rev_cnt_q   <= REV_ZERO;
         last_dir_q  <= 1'b0;
         dir_valid_q <= 1'b0;
         same_seen_q <= 1'b0;
         strobe_q    <= 1'b0;
         locked_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         acc_q       <= acc_d;
         rev_cnt_q   <= rev_cnt_d;
         last_dir_q  <= last_dir_d;
         dir_valid_q <= dir_valid_d;
         same_seen_q <= same_seen_d;
         strobe_q    <= strobe_d;
         locked_q    <= locked_d;
         fault_q     <= fault_d;
      end
   end

   assign delay_code = code_q;
   assign upd_strobe = strobe_q;
   assign locked     = locked_q;
   assign fault      = fault_q;
   assign state      = state_q;

endmodule

// File: tb/tb_dll_lock_ctrl.sv
// Directed bench for dll_lock_ctrl: acquisition, reversal, lock/unlock, saturation and reset cases.
module tb_dll_lock_ctrl;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic       pd_early;
   logic       pd_late;
   logic [5:0] delay_code;
   logic       upd_strobe;
   logic       locked;
   logic       fault;
   logic [2:0] state;

   int n_checks;
   int n_pass;
   int n_fail;

   dll_lock_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .pd_early   (pd_early),
      .pd_late    (pd_late),
      .delay_code (delay_code),
      .upd_strobe (upd_strobe),
      .locked     (locked),
      .fault      (fault),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int code, input int st, input int lk,
                          input int flt, input int stb);
      chk({tag, "_code"},   32'(delay_code), 32'(code));
      chk({tag, "_state"},  32'(state),      32'(st));
      chk({tag, "_locked"}, 32'(locked),     32'(lk));
      chk({tag, "_fault"},  32'(fault),      32'(flt));
      chk({tag, "_strobe"}, 32'(upd_strobe), 32'(stb));
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_fail   = 0;

      // T1: reset wins over ena/early
      rst_n = 1'b0; ena = 1'b1; pd_early = 1'b1; pd_late = 1'b0;
      tick(2);
      chk_all("t1_reset", 32, 0, 0, 0, 0);

      // T2: coarse acquisition upward
      rst_n = 1'b1;
      tick(1);
      chk_all("t2_enter", 32, 1, 0, 0, 0);
      tick(3);
      chk_all("t2_pre", 32, 1, 0, 0, 0);
      tick(1);
      chk_all("t2_up1", 36, 1, 0, 0, 1);
      tick(1);
      chk("t2_strobe_off", 32'(upd_strobe), 32'd0);
      tick(3);
      chk_all("t2_up2", 40, 1, 0, 0, 1);
      tick(4);
      chk_all("t2_up3", 44, 1, 0, 0, 1);

      // T3: first reversal moves by one and enters TRACK
      pd_early = 1'b0; pd_late = 1'b1;
      tick(3);
      chk("t3_hold", 32'(delay_code), 32'd44);
      tick(1);
      chk_all("t3_rev", 43, 2, 0, 0, 1);
      chk("t3_revcnt", 32'(dut.rev_cnt_q), 32'd1);

      // T4: three more reversals lock the loop
      pd_early = 1'b1; pd_late = 1'b0;
      tick(4);
      chk_all("t4_rev2", 44, 2, 0, 0, 1);
      chk("t4_revcnt2", 32'(dut.rev_cnt_q), 32'd2);
      pd_early = 1'b0; pd_late = 1'b1;
      tick(4);
      chk_all("t4_rev3", 43, 2, 0, 0, 1);
      pd_early = 1'b1; pd_late = 1'b0;
      tick(4);
      chk_all("t4_lock", 44, 3, 1, 0, 1);

      // T4b: two same-direction UP events drop lock on the second
      tick(4);
      chk_all("t4_same1", 45, 3, 1, 0, 1);
      tick(4);
      chk_all("t4_same2", 46, 2, 0, 0, 1);
      chk("t4_revcnt_unlock", 32'(dut.rev_cnt_q), 32'd1);

      // Relock, then a reversal inside LOCKED keeps the lock
      pd_early = 1'b0; pd_late = 1'b1;
      tick(4);
      chk_all("t6_relock_a", 45, 2, 0, 0, 1);
      pd_early = 1'b1; pd_late = 1'b0;
      tick(4);
      chk_all("t6_relock_b", 46, 2, 0, 0, 1);
      pd_early = 1'b0; pd_late = 1'b1;
      tick(4);
      chk_all("t6_relock_c", 45, 3, 1, 0, 1);
      pd_early = 1'b1; pd_late = 1'b0;
      tick(4);
      chk_all("t6_dither", 46, 3, 1, 0, 1);

      // T6: single-edge reset while LOCKED (strobe was high before this edge)
      rst_n = 1'b0;
      tick(1);
      chk_all("t6_reset", 32, 0, 0, 0, 0);
      chk("t6_acc", 32'(dut.acc_q), 32'd0);

      // T6b: early and late together never drift the code
      rst_n = 1'b1; pd_early = 1'b1; pd_late = 1'b1;
      tick(20);
      chk_all("t6_both", 32, 1, 0, 0, 0);

      // T5: saturation from reset
      rst_n = 1'b0; pd_early = 1'b1; pd_late = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      chk("t5_acq", 32'(state), 32'd1);
      for (int k = 1; k <= 7; k++) begin
         tick(4);
         chk("t5_step", 32'(delay_code), 32'(32 + 4 * k));
      end
      tick(4);
      chk_all("t5_clamp", 63, 1, 0, 0, 1);
      tick(4);
      chk_all("t5_fault", 63, 4, 0, 1, 0);
      tick(6);
      chk_all("t5_frozen", 63, 4, 0, 1, 0);
      ena = 1'b0;
      tick(1);
      chk_all("t5_idle", 32, 0, 0, 0, 0);

      // Coarse step downward from a fresh acquisition
      ena = 1'b1; pd_early = 1'b0; pd_late = 1'b1;
      tick(1);
      chk("t5_reacq", 32'(state), 32'd1);
      tick(4);
      chk_all("t5_down", 28, 1, 0, 0, 1);

      // ena low in ACQUIRE returns to IDLE immediately
      ena = 1'b0;
      tick(1);
      chk_all("t5_ena_off", 32, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
